// File: rtl/ddr2_fifo_responder_pkg.sv
// Shared encodings for the DDR2 FIFO responder: command codes, engine states, beat geometry.
package ddr2_fifo_responder_pkg;

  localparam int BEAT_W = 128;
  localparam int MASK_W = 16;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR0    = 3'd1;
  localparam logic [2:0] ST_WR1    = 3'd2;
  localparam logic [2:0] ST_RDWAIT = 3'd3;
  localparam logic [2:0] ST_RD0    = 3'd4;
  localparam logic [2:0] ST_RD1    = 3'd5;

endpackage

// File: rtl/ddr2_fifo_responder_if.sv
// Cache-side af/wdf/rdf FIFO bus; master is the client, slave is the responder.
interface ddr2_fifo_responder_if;
  import ddr2_fifo_responder_pkg::*;

  logic [2:0]        af_cmd_din;
  logic [30:0]       af_addr_din;
  logic              af_wr_en;
  logic              af_full;
  logic [BEAT_W-1:0] wdf_din;
  logic [MASK_W-1:0] wdf_mask_din;
  logic              wdf_wr_en;
  logic              wdf_full;
  logic              rdf_valid;
  logic [BEAT_W-1:0] rdf_dout;
  logic              rdf_rd_en;
  logic              busy;
  logic              err;

  modport master (
    output af_cmd_din, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, rdf_rd_en,
    input  af_full, wdf_full, rdf_valid, rdf_dout, busy, err
  );

  modport slave (
    input  af_cmd_din, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, rdf_rd_en,
    output af_full, wdf_full, rdf_valid, rdf_dout, busy, err
  );

endinterface

// File: rtl/ddr2_fifo_responder_resp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy count.
// A push into a full queue is dropped and flagged on overflow, even if a pop happens the same cycle.
module resp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign overflow = push & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ddr2_fifo_responder.sv
// Block-RAM memory model behind the af/wdf/rdf DDR2 FIFO protocol; serves 256-bit
// writes and reads strictly in command order, returning reads as two 128-bit beats.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | inspect head command; wait for 2 write beats or 2 read slots
// WR0       | commit write beat 0 into word {line,0} under byte mask
// WR1       | commit write beat 1 into word {line,1}
// RDWAIT    | count down the read latency
// RD0       | push word {line,0} into the read queue
// RD1       | push word {line,1} into the read queue
module ddr2_fifo_responder
  import ddr2_fifo_responder_pkg::*;
#(
  parameter int LINE_AW   = 10,
  parameter int AF_DEPTH  = 8,
  parameter int WDF_DEPTH = 16,
  parameter int RDF_DEPTH = 16,
  parameter int READ_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ddr2_fifo_responder_if.slave  bus
);

  localparam int WA     = LINE_AW + 1;
  localparam int AF_W   = 3 + LINE_AW;
  localparam int WDF_W  = BEAT_W + MASK_W;
  localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
  localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;
  localparam int RDF_CW = $clog2(RDF_DEPTH) + 1;
  localparam int LAT_W  = $clog2(READ_LAT + 1);

  logic [AF_W-1:0]    af_head;
  logic [AF_CW-1:0]   af_count_unused;
  logic               af_empty;
  logic               af_full;
  logic               af_ovf;
  logic               af_pop;

  logic [WDF_W-1:0]   wdf_head;
  logic [WDF_CW-1:0]  wdf_count;
  logic               wdf_empty;
  logic               wdf_full;
  logic               wdf_ovf;
  logic               wdf_pop;

  logic [BEAT_W-1:0]  rdf_head;
  logic [RDF_CW-1:0]  rdf_count;
  logic               rdf_empty;
  logic               rdf_full_unused;
  logic               rdf_ovf;
  logic               rdf_push;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [LAT_W-1:0]   lat_nxt;
  logic [LINE_AW-1:0] line_q;
  logic [LINE_AW-1:0] line_nxt;
  logic               err_q;
  logic               cmd_err;
  logic               ram_we;

  logic [2:0]         head_cmd;
  logic [LINE_AW-1:0] head_line;
  logic [BEAT_W-1:0]  wdf_data;
  logic [MASK_W-1:0]  wdf_mask;
  logic               beat_sel;
  logic [WA-1:0]      word_idx;
  logic [BEAT_W-1:0]  ram_rdata;
  logic               unused_addr_bits;

  logic [BEAT_W-1:0]  ram [2**WA];

  resp_sync_fifo #(.WIDTH(AF_W), .DEPTH(AF_DEPTH)) u_af (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.af_wr_en),
    .din      ({bus.af_cmd_din, bus.af_addr_din[LINE_AW+1:2]}),
    .pop      (af_pop),
    .dout     (af_head),
    .count    (af_count_unused),
    .full     (af_full),
    .empty    (af_empty),
    .overflow (af_ovf)
  );

  resp_sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.wdf_wr_en),
    .din      ({bus.wdf_mask_din, bus.wdf_din}),
    .pop      (wdf_pop),
    .dout     (wdf_head),
    .count    (wdf_count),
    .full     (wdf_full),
    .empty    (wdf_empty),
    .overflow (wdf_ovf)
  );

  resp_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(RDF_DEPTH)) u_rdf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rdf_push),
    .din      (ram_rdata),
    .pop      (bus.rdf_rd_en),
    .dout     (rdf_head),
    .count    (rdf_count),
    .full     (rdf_full_unused),
    .empty    (rdf_empty),
    .overflow (rdf_ovf)
  );

  assign unused_addr_bits = ^{bus.af_addr_din[30:LINE_AW+2], bus.af_addr_din[1:0]};

  assign head_cmd  = af_head[AF_W-1 -: 3];
  assign head_line = af_head[LINE_AW-1:0];
  assign wdf_data  = wdf_head[BEAT_W-1:0];
  assign wdf_mask  = wdf_head[WDF_W-1 -: MASK_W];
  assign beat_sel  = (state == ST_WR1) || (state == ST_RD1);
  assign word_idx  = {line_q, beat_sel};
  assign ram_rdata = ram[word_idx];

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    line_nxt  = line_q;
    af_pop    = 1'b0;
    wdf_pop   = 1'b0;
    rdf_push  = 1'b0;
    ram_we    = 1'b0;
    cmd_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!af_empty) begin
          case (head_cmd)
            CMD_WRITE: begin
              if (wdf_count >= WDF_CW'(2)) begin
                af_pop    = 1'b1;
                line_nxt  = head_line;
                state_nxt = ST_WR0;
              end
            end
            CMD_READ: begin
              // Both return slots are reserved here, so RD0/RD1 can never overflow rdf.
              if (rdf_count <= RDF_CW'(RDF_DEPTH - 2)) begin
                af_pop    = 1'b1;
                line_nxt  = head_line;
                lat_nxt   = LAT_W'(READ_LAT - 1);
                state_nxt = ST_RDWAIT;
              end
            end
            default: begin
              af_pop  = 1'b1;
              cmd_err = 1'b1;
            end
          endcase
        end
      end
      ST_WR0: begin
        wdf_pop   = 1'b1;
        ram_we    = 1'b1;
        state_nxt = ST_WR1;
      end
      ST_WR1: begin
        wdf_pop   = 1'b1;
        ram_we    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_RDWAIT: begin
        if (lat_cnt == '0) state_nxt = ST_RD0;
        else               lat_nxt   = lat_cnt - 1'b1;
      end
      ST_RD0: begin
        rdf_push  = 1'b1;
        state_nxt = ST_RD1;
      end
      ST_RD1: begin
        rdf_push  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      line_q  <= line_nxt;
      err_q   <= err_q | af_ovf | wdf_ovf | rdf_ovf | cmd_err;
    end
  end

  // Memory survives reset; a set mask bit leaves that byte untouched.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wdf_mask[b]) ram[word_idx][b*8 +: 8] <= wdf_data[b*8 +: 8];
      end
    end
  end

  assign bus.af_full   = af_full;
  assign bus.wdf_full  = wdf_full;
  assign bus.rdf_valid = ~rdf_empty;
  assign bus.rdf_dout  = rdf_head;
  assign bus.err       = err_q;
  assign bus.busy      = (state != ST_IDLE) | ~af_empty | ~wdf_empty | ~rdf_empty;

endmodule
